// File: rtl/audio_stream_ctrl.sv
// audio_stream_ctrl
//   Sequencer between the codec FIFO handshake and the effect datapath.
//   One stereo sample in flight: IDLE -> READ -> (PROC) -> LOAD -> WRITE.
//   The output register is loaded on the edge entering LOAD, so audio_out_L/R
//   sit stable for the whole LOAD cycle before write_audio_out can rise in WRITE.
//
// Ports
//   CLOCK_50, reset                 clock, synchronous active-high reset
//   audio_in_available/_L/_R        codec input side, read_audio_in pops it
//   audio_out_allowed               codec output ready, write_audio_out pushes
//   audio_out_L/_R                  registered output sample
//   mute, bypass                    zero output / skip effect core
//   proc_start_o, proc_L/R_o        start pulse and raw sample to effect core
//   proc_done_i, proc_L/R_i         effect result
//   timeout_o                       one-cycle pulse when the effect core times out
//   sample_count, overrun_count     completed writes / overrun events
//
// Optional feature macro: AUDIO_CTRL_OVERRUN_CNT_EN
//   defined   -> saturating overrun counter (one count per stalled sample)
//   undefined -> overrun_count tied to 0
module audio_stream_ctrl #(
  parameter int DATA_W       = 32,
  parameter int PROC_TIMEOUT = 64,
  parameter int CNT_W        = 16
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              audio_in_available,
  input  logic              audio_out_allowed,
  input  logic [DATA_W-1:0] audio_in_L,
  input  logic [DATA_W-1:0] audio_in_R,
  output logic              read_audio_in,
  output logic              write_audio_out,
  output logic [DATA_W-1:0] audio_out_L,
  output logic [DATA_W-1:0] audio_out_R,
  input  logic              mute,
  input  logic              bypass,
  output logic              proc_start_o,
  output logic [DATA_W-1:0] proc_L_o,
  output logic [DATA_W-1:0] proc_R_o,
  input  logic              proc_done_i,
  input  logic [DATA_W-1:0] proc_L_i,
  input  logic [DATA_W-1:0] proc_R_i,
  output logic              timeout_o,
  output logic [CNT_W-1:0]  sample_count,
  output logic [CNT_W-1:0]  overrun_count
);

  localparam int TW = (PROC_TIMEOUT > 2) ? $clog2(PROC_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(PROC_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_PROC, S_LOAD, S_WRITE} state_t;

  state_t            r_state, w_next;
  logic [TW-1:0]     r_timer;
  logic [DATA_W-1:0] r_raw_L, r_raw_R;
  logic [DATA_W-1:0] r_out_L, r_out_R;
  logic [CNT_W-1:0]  r_sample_cnt;
  logic              w_timeout;

  always_ff @(posedge CLOCK_50) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next          = r_state;
    read_audio_in   = 1'b0;
    write_audio_out = 1'b0;
    proc_start_o    = 1'b0;
    w_timeout       = 1'b0;
    case (r_state)
      S_IDLE:  if (audio_in_available) w_next = S_READ;
      S_READ: begin
        read_audio_in = 1'b1;
        w_next        = bypass ? S_LOAD : S_PROC;
      end
      S_PROC: begin
        proc_start_o = (r_timer == '0);
        if (proc_done_i)            w_next = S_LOAD;
        else if (r_timer == TMAX) begin
          w_timeout = 1'b1;
          w_next    = S_LOAD;
        end
      end
      S_LOAD:  w_next = S_WRITE;
      S_WRITE: begin
        write_audio_out = audio_out_allowed;
        if (audio_out_allowed) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath. The output register takes its value on the edge that enters
  // LOAD (from READ when bypassed, from PROC otherwise); mute is sampled at
  // that single edge, so a sample is never altered once it is committed.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_timer      <= '0;
      r_raw_L      <= '0;
      r_raw_R      <= '0;
      r_out_L      <= '0;
      r_out_R      <= '0;
      r_sample_cnt <= '0;
    end else begin
      case (r_state)
        S_READ: begin
          r_raw_L <= audio_in_L;
          r_raw_R <= audio_in_R;
          r_timer <= '0;
          if (bypass) begin
            r_out_L <= mute ? '0 : audio_in_L;
            r_out_R <= mute ? '0 : audio_in_R;
          end
        end
        S_PROC: begin
          r_timer <= r_timer + 1'b1;
          if (proc_done_i) begin
            r_out_L <= mute ? '0 : proc_L_i;
            r_out_R <= mute ? '0 : proc_R_i;
          end else if (w_timeout) begin
            r_out_L <= mute ? '0 : r_raw_L;
            r_out_R <= mute ? '0 : r_raw_R;
          end
        end
        S_WRITE: if (audio_out_allowed) r_sample_cnt <= r_sample_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign audio_out_L  = r_out_L;
  assign audio_out_R  = r_out_R;
  assign proc_L_o     = r_raw_L;
  assign proc_R_o     = r_raw_R;
  assign timeout_o    = w_timeout;
  assign sample_count = r_sample_cnt;

`ifdef AUDIO_CTRL_OVERRUN_CNT_EN
  // r_ovr_seen limits counting to one event per stalled sample.
  logic             r_ovr_seen;
  logic [CNT_W-1:0] r_ovr_cnt;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_ovr_seen <= 1'b0;
      r_ovr_cnt  <= '0;
    end else if (r_state == S_LOAD) begin
      r_ovr_seen <= 1'b0;
    end else if (r_state == S_WRITE && audio_in_available && !audio_out_allowed
                 && !r_ovr_seen) begin
      r_ovr_seen <= 1'b1;
      if (r_ovr_cnt != '1) r_ovr_cnt <= r_ovr_cnt + 1'b1;
    end
  end

  assign overrun_count = r_ovr_cnt;
`else
  assign overrun_count = '0;
`endif

endmodule

// File: tb/tb_audio_stream_ctrl.sv
module tb_audio_stream_ctrl;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          CLOCK_50 = 1'b0;
  logic          reset;
  logic          audio_in_available, audio_out_allowed;
  logic [DW-1:0] audio_in_L, audio_in_R;
  logic          read_audio_in, write_audio_out;
  logic [DW-1:0] audio_out_L, audio_out_R;
  logic          mute, bypass;
  logic          proc_start_o;
  logic [DW-1:0] proc_L_o, proc_R_o;
  logic          proc_done_i;
  logic [DW-1:0] proc_L_i, proc_R_i;
  logic          timeout_o;
  logic [CW-1:0] sample_count, overrun_count;

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;
  logic [2*DW-1:0] exp_q[$];

  always #5 CLOCK_50 = ~CLOCK_50;

  audio_stream_ctrl #(.DATA_W(DW), .PROC_TIMEOUT(4), .CNT_W(CW)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .audio_in_available(audio_in_available), .audio_out_allowed(audio_out_allowed),
    .audio_in_L(audio_in_L), .audio_in_R(audio_in_R),
    .read_audio_in(read_audio_in), .write_audio_out(write_audio_out),
    .audio_out_L(audio_out_L), .audio_out_R(audio_out_R),
    .mute(mute), .bypass(bypass),
    .proc_start_o(proc_start_o), .proc_L_o(proc_L_o), .proc_R_o(proc_R_o),
    .proc_done_i(proc_done_i), .proc_L_i(proc_L_i), .proc_R_i(proc_R_i),
    .timeout_o(timeout_o), .sample_count(sample_count), .overrun_count(overrun_count)
  );

  // Effect core model: doubles the sample, done asserted done_delay cycles
  // after the start pulse (0 = never answers).
  int       done_delay = 1;
  logic [7:0] m_cnt;
  always @(posedge CLOCK_50) begin
    if (reset || proc_done_i || timeout_o) m_cnt <= 8'd0;
    else if (proc_start_o)                 m_cnt <= 8'd1;
    else if (m_cnt != 8'd0 && m_cnt != 8'hFF) m_cnt <= m_cnt + 8'd1;
  end
  assign proc_done_i = (done_delay != 0) && (int'(m_cnt) == done_delay);
  assign proc_L_i    = proc_L_o << 1;
  assign proc_R_i    = proc_R_o << 1;

  // Drives one sample from IDLE and observes until the write (bounded).
  // lat is the cycle index of the write relative to the available cycle.
  task automatic run_sample(input logic [DW-1:0] l, input logic [DW-1:0] r,
                            output int lat, output int starts, output int tos,
                            output int clash, output logic [2*DW-1:0] o,
                            output logic [2*DW-1:0] prev);
    @(posedge CLOCK_50); #1;
    audio_in_L = l; audio_in_R = r; audio_in_available = 1'b1;
    lat = -1; starts = 0; tos = 0; clash = 0; o = '0;
    prev = {audio_out_L, audio_out_R};
    for (int c = 0; c < 40; c++) begin
      @(negedge CLOCK_50);
      if (c == 1) audio_in_available = 1'b0;
      if (proc_start_o) starts++;
      if (timeout_o) tos++;
      if (read_audio_in && write_audio_out) clash++;
      if (write_audio_out) begin
        lat = c; o = {audio_out_L, audio_out_R};
        break;
      end
      prev = {audio_out_L, audio_out_R};
    end
    @(posedge CLOCK_50); #1;
  endtask

  task automatic test_reset();
    logic [2*DW+CW*2+5:0] got;
    reset = 1'b1; audio_in_available = 1'b0; audio_out_allowed = 1'b1;
    audio_in_L = '0; audio_in_R = '0; mute = 1'b0; bypass = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    got = {read_audio_in, write_audio_out, proc_start_o, timeout_o, 2'b00,
           audio_out_L, audio_out_R, sample_count, overrun_count};
    tests++;
    if (got !== '0 || proc_L_o !== '0 || proc_R_o !== '0) begin
      fails++; $display("FAIL reset_state: got %h want 0", got);
    end
    #1 reset = 1'b0;
  endtask

  task automatic test_effect();
    int lat, st, to, cl; logic [2*DW-1:0] o, p, e;
    done_delay = 1;
    exp_q.push_back({32'd2000, 32'(-2000)});
    run_sample(32'd1000, 32'(-1000), lat, st, to, cl, o, p);
    tests++;
    if (lat != 5) begin fails++; $display("FAIL effect_latency: got %0d want 5", lat); end
    if (exp_q.size() == 0) begin
      tests++; fails++; $display("FAIL effect_sb: queue empty");
    end else begin
      e = exp_q.pop_front();
      tests++;
      if (o !== e) begin fails++; $display("FAIL effect_out: got %h want %h", o, e); end
      tests++;
      if (p !== e) begin fails++; $display("FAIL effect_prestable: got %h want %h", p, e); end
    end
    tests++;
    if (st != 1 || cl != 0) begin
      fails++; $display("FAIL effect_start: starts %0d clash %0d want 1/0", st, cl);
    end
    exp_cnt++;
    tests++;
    if (sample_count !== CW'(exp_cnt)) begin
      fails++; $display("FAIL effect_count: got %0d want %0d", sample_count, exp_cnt);
    end
  endtask

  task automatic test_mute();
    int lat, st, to, cl; logic [2*DW-1:0] o, p, e;
    mute = 1'b1; done_delay = 1;
    exp_q.push_back('0);
    run_sample(32'd5000, 32'd5000, lat, st, to, cl, o, p);
    mute = 1'b0;
    e = exp_q.pop_front();
    tests++;
    if (lat != 5 || o !== e) begin
      fails++; $display("FAIL mute_out: lat %0d out %h want 5/%h", lat, o, e);
    end
    tests++;
    if (st != 1) begin fails++; $display("FAIL mute_start: got %0d want 1", st); end
    exp_cnt++;
  endtask

  task automatic test_bypass();
    int lat, st, to, cl; logic [2*DW-1:0] o, p, e;
    bypass = 1'b1;
    exp_q.push_back({32'hDEADBEEF, 32'hDEADBEEF});
    run_sample(32'hDEADBEEF, 32'hDEADBEEF, lat, st, to, cl, o, p);
    bypass = 1'b0;
    e = exp_q.pop_front();
    tests++;
    if (lat != 3) begin fails++; $display("FAIL bypass_latency: got %0d want 3", lat); end
    tests++;
    if (o !== e) begin fails++; $display("FAIL bypass_out: got %h want %h", o, e); end
    tests++;
    if (st != 0) begin fails++; $display("FAIL bypass_start: got %0d want 0", st); end
    exp_cnt++;
  endtask

  task automatic test_timeout();
    int lat, st, to, cl; logic [2*DW-1:0] o, p, e;
    done_delay = 0;
    exp_q.push_back({32'd123, 32'd456});
    run_sample(32'd123, 32'd456, lat, st, to, cl, o, p);
    e = exp_q.pop_front();
    tests++;
    if (to != 1 || lat != 7) begin
      fails++; $display("FAIL timeout_pulse: pulses %0d lat %0d want 1/7", to, lat);
    end
    tests++;
    if (o !== e) begin fails++; $display("FAIL timeout_out: got %h want %h", o, e); end
    exp_cnt++;
    // done arrives on the 4th (timeout) PROC cycle: done wins
    done_delay = 3;
    exp_q.push_back({32'd246, 32'd912});
    run_sample(32'd123, 32'd456, lat, st, to, cl, o, p);
    e = exp_q.pop_front();
    tests++;
    if (to != 0 || lat != 7) begin
      fails++; $display("FAIL done_wins_pulse: pulses %0d lat %0d want 0/7", to, lat);
    end
    tests++;
    if (o !== e) begin fails++; $display("FAIL done_wins_out: got %h want %h", o, e); end
    exp_cnt++;
    done_delay = 1;
  endtask

  task automatic test_backpressure();
    int wr, rd, bad, wr2; logic [2*DW-1:0] e, o;
    done_delay = 1; audio_out_allowed = 1'b0;
    exp_q.push_back({32'd14, 32'd18});
    e = exp_q[0];
    @(posedge CLOCK_50); #1;
    audio_in_L = 32'd7; audio_in_R = 32'd9; audio_in_available = 1'b1;
    wr = 0; rd = 0; bad = 0; wr2 = 0; o = '0;
    for (int c = 0; c < 15; c++) begin
      @(negedge CLOCK_50);
      if (write_audio_out) wr++;
      if (c >= 5) begin
        if (read_audio_in) rd++;
        if ({audio_out_L, audio_out_R} !== e) bad++;
      end
    end
    tests++;
    if (wr != 0 || rd != 0) begin
      fails++; $display("FAIL bp_hold: writes %0d reads %0d want 0/0", wr, rd);
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL bp_outputs_held: %0d bad cycles want 0", bad); end
    @(posedge CLOCK_50); #1;
    audio_out_allowed = 1'b1; audio_in_available = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLOCK_50);
      if (write_audio_out) begin wr2++; o = {audio_out_L, audio_out_R}; end
    end
    e = exp_q.pop_front();
    exp_cnt++;
    tests++;
    if (wr2 != 1 || o !== e) begin
      fails++; $display("FAIL bp_release: writes %0d out %h want 1/%h", wr2, o, e);
    end
    tests++;
`ifdef AUDIO_CTRL_OVERRUN_CNT_EN
    if (overrun_count !== CW'(1)) begin
      fails++; $display("FAIL bp_overrun: got %0d want 1", overrun_count);
    end
`else
    if (overrun_count !== '0) begin
      fails++; $display("FAIL bp_overrun: got %0d want 0", overrun_count);
    end
`endif
    tests++;
    if (sample_count !== CW'(exp_cnt)) begin
      fails++; $display("FAIL bp_count: got %0d want %0d", sample_count, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int lat, st, to, cl; logic [2*DW-1:0] o, p, e;
    logic [2*DW+CW*2+3:0] got;
    done_delay = 1;
    @(posedge CLOCK_50); #1;
    audio_in_L = 32'd11; audio_in_R = 32'd22; audio_in_available = 1'b1;
    @(posedge CLOCK_50); #1; audio_in_available = 1'b0;   // READ
    @(posedge CLOCK_50); #1; reset = 1'b1;                // PROC
    @(posedge CLOCK_50); #1; reset = 1'b0;
    @(negedge CLOCK_50);
    got = {read_audio_in, write_audio_out, proc_start_o, timeout_o,
           audio_out_L, audio_out_R, sample_count, overrun_count};
    tests++;
    if (got !== '0 || proc_L_o !== '0) begin
      fails++; $display("FAIL reset_mid_state: got %h want 0", got);
    end
    exp_cnt = 0;
    exp_q.push_back({32'd66, 32'd88});
    run_sample(32'd33, 32'd44, lat, st, to, cl, o, p);
    e = exp_q.pop_front();
    exp_cnt++;
    tests++;
    if (lat != 5 || o !== e) begin
      fails++; $display("FAIL reset_mid_next: lat %0d out %h want 5/%h", lat, o, e);
    end
    tests++;
    if (sample_count !== CW'(exp_cnt)) begin
      fails++; $display("FAIL reset_mid_count: got %0d want %0d", sample_count, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_effect();
    test_mute();
    test_bypass();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
